spio_spinnaker_link_rx_checker: RTL and testbench



---
 rtl/spio_link_chk_pkg.sv | 52 +++++
 rtl/spio_link_chk_fifo.sv | 41 ++++
 rtl/spio_spinnaker_link_rx_checker.sv | 141 ++++++++++++++
 tb/tb_spio_spinnaker_link_rx_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spio_link_chk_pkg.sv
// spio_link_chk_pkg: packet field ranges, 2-of-7 symbol decode and checker state for the link rx checker.
package spio_link_chk_pkg;
    localparam int PKT_W = 72;
    localparam int PKT_HDR_RNG [2] = '{7, 0};
    localparam int PKT_KEY_RNG [2] = '{39, 8};
    localparam int PKT_PLD_RNG [2] = '{71, 40};
    localparam logic [6:0] EOP_CODE = 7'b1100000;

    typedef enum logic [1:0] {RST_ACK, WAIT, DELAY} state_t;
    typedef enum logic [1:0] {SYM_DATA, SYM_EOP, SYM_ERR} sym_t;

    // Returns {valid, nibble}
    function automatic logic [4:0] decode_2of7(input logic [6:0] s);
        case (s)
            7'b0010001: return 5'h10;
            7'b0010010: return 5'h11;
            7'b0010100: return 5'h12;
            7'b0011000: return 5'h13;
            7'b0100001: return 5'h14;
            7'b0100010: return 5'h15;
            7'b0100100: return 5'h16;
            7'b0101000: return 5'h17;
            7'b1000001: return 5'h18;
            7'b1000010: return 5'h19;
            7'b1000100: return 5'h1a;
            7'b1001000: return 5'h1b;
            7'b0000011: return 5'h1c;
            7'b0000110: return 5'h1d;
            7'b0001100: return 5'h1e;
            7'b0001001: return 5'h1f;
            default:    return 5'h00;
        endcase
    endfunction

    function automatic sym_t classify_sym(input logic [6:0] s);
        logic [4:0] d;
        d = decode_2of7(s);
        return s == EOP_CODE ? SYM_EOP : d[4] ? SYM_DATA : SYM_ERR;
    endfunction

    function automatic logic [7:0] pkt_hdr(input logic [PKT_W-1:0] p);
        return p[PKT_HDR_RNG[1] +: 8];
    endfunction

    function automatic logic [31:0] pkt_key(input logic [PKT_W-1:0] p);
        return p[PKT_KEY_RNG[1] +: 32];
    endfunction

    function automatic logic [31:0] pkt_pld(input logic [PKT_W-1:0] p);
        return p[PKT_PLD_RNG[1] +: 32];
    endfunction
endpackage

// File: rtl/spio_link_chk_fifo.sv
// spio_link_chk_fifo: sync FIFO with full/empty flags, same-cycle push/pop and dropped-push strobe.
module spio_link_chk_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int W = 72
) (
    input  logic         tb_clk,
    input  logic         tb_rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic         ovf
);
    logic [W-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wptr, rptr;
    logic push_ok, pop_ok;

    assign empty = wptr == rptr;
    assign full = wptr == {~rptr[DEPTH_LOG2], rptr[DEPTH_LOG2-1:0]};
    assign pop_ok = pop && !empty;
    // A pop in the same cycle frees the slot being written, so a full push is still taken
    assign push_ok = push && (!full || pop_ok);
    assign ovf = push && full && !pop_ok;
    assign rd_data = mem[rptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge tb_clk) begin
        if (push_ok) mem[wptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
endmodule

// File: rtl/spio_spinnaker_link_rx_checker.sv
// spio_spinnaker_link_rx_checker: 2-of-7 link receiver, packet reassembly and expected-packet scoreboard.
// Optional odd-parity check over each received packet enabled by SPIO_RX_CHK_PARITY_EN.
module spio_spinnaker_link_rx_checker
    import spio_link_chk_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int ACK_DLY = 4,
    parameter int CNT_W = 16
) (
    input  logic             tb_clk,
    input  logic             tb_rst,
    input  logic [71:0]      EXP_PKT_DATA_IN,
    input  logic             EXP_PKT_VLD_IN,
    output logic             EXP_FULL_OUT,
    input  logic [6:0]       SL_DATA_2OF7_IN,
    output logic             SL_ACK_OUT,
    output logic [71:0]      RX_PKT_DATA_OUT,
    output logic             RX_PKT_VLD_OUT,
    output logic             BAD_PKT_OUT,
    output logic [CNT_W-1:0] PKT_OK_CNT_OUT,
    output logic [CNT_W-1:0] PKT_BAD_CNT_OUT,
    output logic [CNT_W-1:0] ORPHAN_CNT_OUT,
    output logic [CNT_W-1:0] OVF_CNT_OUT,
    output logic [CNT_W-1:0] SYM_ERR_CNT_OUT,
    output logic [CNT_W-1:0] PAR_ERR_CNT_OUT
);
    logic [6:0] sync1, sd, old_data, diff;
    state_t state;
    sym_t cls;
    logic [7:0] dly_cnt;
    logic [4:0] flit_cnt, dec;
    logic [71:0] rx_buf, exp_pkt;
    logic pkt_bad, exp_empty, fifo_ovf, complete, is_eop, pop, long_pkt, par_ok, pkt_good;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(~&c);
    endfunction

    // Synchroniser is left out of reset so sd is already valid when RST_ACK samples it
    always_ff @(posedge tb_clk) begin
        sync1 <= SL_DATA_2OF7_IN;
        sd <= sync1;
    end

    assign diff = sd ^ old_data;
    assign dec = decode_2of7(diff);
    assign cls = classify_sym(diff);
    assign complete = state == WAIT && $countones(diff) >= 2;
    assign is_eop = complete && cls == SYM_EOP;
    assign pop = is_eop && !exp_empty;
    assign long_pkt = rx_buf[1];

`ifdef SPIO_RX_CHK_PARITY_EN
    assign par_ok = ^(long_pkt ? rx_buf : {32'b0, rx_buf[39:0]});
    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) PAR_ERR_CNT_OUT <= '0;
        else if (is_eop && !par_ok) PAR_ERR_CNT_OUT <= sat_inc(PAR_ERR_CNT_OUT);
    end
`else
    assign par_ok = 1'b1;
    assign PAR_ERR_CNT_OUT = '0;
`endif

    assign pkt_good = !exp_empty && !pkt_bad && par_ok
                   && flit_cnt == (long_pkt ? 5'd18 : 5'd10)
                   && pkt_hdr(rx_buf) == pkt_hdr(exp_pkt)
                   && pkt_key(rx_buf) == pkt_key(exp_pkt)
                   && (!long_pkt || pkt_pld(rx_buf) == pkt_pld(exp_pkt));

    spio_link_chk_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2), .W(PKT_W)) u_fifo (
        .tb_clk(tb_clk),
        .tb_rst(tb_rst),
        .push(EXP_PKT_VLD_IN),
        .pop(pop),
        .wr_data(EXP_PKT_DATA_IN),
        .rd_data(exp_pkt),
        .full(EXP_FULL_OUT),
        .empty(exp_empty),
        .ovf(fifo_ovf)
    );

    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            state <= RST_ACK;
            SL_ACK_OUT <= 1'b0;
            old_data <= '0;
            dly_cnt <= '0;
            flit_cnt <= '0;
            pkt_bad <= 1'b0;
            rx_buf <= '0;
            RX_PKT_DATA_OUT <= '0;
            RX_PKT_VLD_OUT <= 1'b0;
            BAD_PKT_OUT <= 1'b0;
            PKT_OK_CNT_OUT <= '0;
            PKT_BAD_CNT_OUT <= '0;
            ORPHAN_CNT_OUT <= '0;
            OVF_CNT_OUT <= '0;
            SYM_ERR_CNT_OUT <= '0;
        end else begin
            RX_PKT_VLD_OUT <= 1'b0;
            if (fifo_ovf) OVF_CNT_OUT <= sat_inc(OVF_CNT_OUT);
            case (state)
                RST_ACK: begin
                    SL_ACK_OUT <= 1'b1;
                    old_data <= sd;
                    state <= WAIT;
                end
                WAIT: if (complete) begin
                    dly_cnt <= 8'(ACK_DLY - 1);
                    state <= DELAY;
                    if (cls == SYM_DATA) begin
                        if (flit_cnt == 5'd18) pkt_bad <= 1'b1;
                        else begin
                            rx_buf[{flit_cnt, 2'b00} +: 4] <= dec[3:0];
                            flit_cnt <= flit_cnt + 5'd1;
                        end
                    end else if (cls == SYM_EOP) begin
                        RX_PKT_DATA_OUT <= rx_buf;
                        RX_PKT_VLD_OUT <= 1'b1;
                        BAD_PKT_OUT <= !pkt_good;
                        if (pkt_good) PKT_OK_CNT_OUT <= sat_inc(PKT_OK_CNT_OUT);
                        else PKT_BAD_CNT_OUT <= sat_inc(PKT_BAD_CNT_OUT);
                        if (exp_empty) ORPHAN_CNT_OUT <= sat_inc(ORPHAN_CNT_OUT);
                        flit_cnt <= '0;
                        pkt_bad <= 1'b0;
                        rx_buf <= '0;
                    end else begin
                        SYM_ERR_CNT_OUT <= sat_inc(SYM_ERR_CNT_OUT);
                        pkt_bad <= 1'b1;
                    end
                end
                DELAY: if (dly_cnt == 8'd0) begin
                    SL_ACK_OUT <= ~SL_ACK_OUT;
                    old_data <= sd;
                    state <= WAIT;
                end else dly_cnt <= dly_cnt - 8'd1;
                default: state <= RST_ACK;
            endcase
        end
    end
endmodule

// File: tb/tb_spio_spinnaker_link_rx_checker.sv
// tb_spio_spinnaker_link_rx_checker: directed bench driving 2-of-7 symbols and expected packets.
module tb_spio_spinnaker_link_rx_checker;
    localparam int ACK_DLY = 4;
    localparam int ACK_LAT = ACK_DLY + 3;
    localparam logic [6:0] EOP = 7'b1100000;
    localparam logic [71:0] P_SHORT = {32'h0, 32'h00000001, 8'h00};
    localparam logic [71:0] P_LONG = {32'ha5a5a5a5, 32'h00000002, 8'h02};

    logic tb_clk, tb_rst, exp_vld, full, ack, rx_vld, bad;
    logic [71:0] exp_data, rx_data;
    logic [6:0] link;
    logic [15:0] ok_cnt, bad_cnt, orphan_cnt, ovf_cnt, sym_cnt, par_cnt;
    int checks, errors, vld_seen;
    logic last_bad;

    spio_spinnaker_link_rx_checker #(.FIFO_DEPTH_LOG2(3), .ACK_DLY(ACK_DLY), .CNT_W(16)) dut (
        .tb_clk(tb_clk), .tb_rst(tb_rst),
        .EXP_PKT_DATA_IN(exp_data), .EXP_PKT_VLD_IN(exp_vld), .EXP_FULL_OUT(full),
        .SL_DATA_2OF7_IN(link), .SL_ACK_OUT(ack),
        .RX_PKT_DATA_OUT(rx_data), .RX_PKT_VLD_OUT(rx_vld), .BAD_PKT_OUT(bad),
        .PKT_OK_CNT_OUT(ok_cnt), .PKT_BAD_CNT_OUT(bad_cnt), .ORPHAN_CNT_OUT(orphan_cnt),
        .OVF_CNT_OUT(ovf_cnt), .SYM_ERR_CNT_OUT(sym_cnt), .PAR_ERR_CNT_OUT(par_cnt)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    always @(negedge tb_clk) if (rx_vld) begin
        vld_seen++;
        last_bad = bad;
    end

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0010001;  4'h1: return 7'b0010010;
            4'h2: return 7'b0010100;  4'h3: return 7'b0011000;
            4'h4: return 7'b0100001;  4'h5: return 7'b0100010;
            4'h6: return 7'b0100100;  4'h7: return 7'b0101000;
            4'h8: return 7'b1000001;  4'h9: return 7'b1000010;
            4'ha: return 7'b1000100;  4'hb: return 7'b1001000;
            4'hc: return 7'b0000011;  4'hd: return 7'b0000110;
            4'he: return 7'b0001100;  default: return 7'b0001001;
        endcase
    endfunction

    task automatic send_sym(input logic [6:0] code, output int lat);
        logic prev;
        prev = ack;
        link = link ^ code;
        lat = 0;
        while (ack === prev && lat < 50) begin
            @(negedge tb_clk);
            lat++;
        end
    endtask

    task automatic send_pkt(input logic [71:0] p, input int n, output int bad_lat);
        int lat;
        bad_lat = 0;
        for (int i = 0; i < n; i++) begin
            send_sym(enc(p[i*4 +: 4]), lat);
            if (lat != ACK_LAT) bad_lat++;
        end
        send_sym(EOP, lat);
        if (lat != ACK_LAT) bad_lat++;
    endtask

    task automatic push(input logic [71:0] p);
        exp_data = p;
        exp_vld = 1'b1;
        @(negedge tb_clk);
        exp_vld = 1'b0;
    endtask

    task automatic test_reset;
        repeat (4) @(negedge tb_clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b expected 0", ack); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
        checks++; if (rx_vld !== 1'b0 || bad !== 1'b0) begin errors++; $display("FAIL reset_vld_bad: got %0b/%0b expected 0/0", rx_vld, bad); end
        checks++; if (rx_data !== 72'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", rx_data); end
        checks++; if ({ok_cnt, bad_cnt, orphan_cnt, ovf_cnt, sym_cnt, par_cnt} !== 96'h0) begin
            errors++; $display("FAIL reset_cnts: got %0h expected 0", {ok_cnt, bad_cnt, orphan_cnt, ovf_cnt, sym_cnt, par_cnt});
        end
        tb_rst = 1'b0;
        @(negedge tb_clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL init_ack: got %0b expected 1", ack); end
    endtask

    task automatic test_short_pkt;
        int lat, toggles, v0;
        push(P_SHORT);
        v0 = vld_seen;
        toggles = 0;
        for (int i = 0; i < 11; i++) begin
            send_sym(i < 10 ? enc(P_SHORT[i*4 +: 4]) : EOP, lat);
            if (lat < 50) toggles++;
            checks++; if (lat != ACK_LAT) begin errors++; $display("FAIL ack_lat[%0d]: got %0d expected %0d", i, lat, ACK_LAT); end
        end
        checks++; if (toggles != 11) begin errors++; $display("FAIL ack_toggles: got %0d expected 11", toggles); end
        checks++; if (vld_seen - v0 != 1) begin errors++; $display("FAIL short_vld: got %0d expected 1", vld_seen - v0); end
        checks++; if (last_bad !== 1'b0) begin errors++; $display("FAIL short_bad: got %0b expected 0", last_bad); end
        checks++; if (ok_cnt !== 16'd1) begin errors++; $display("FAIL short_ok_cnt: got %0d expected 1", ok_cnt); end
        checks++; if (rx_data !== P_SHORT) begin errors++; $display("FAIL short_data: got %0h expected %0h", rx_data, P_SHORT); end
    endtask

    task automatic test_long_pkt;
        int bl;
        push(P_LONG);
        send_pkt(P_LONG, 18, bl);
        checks++; if (bl != 0) begin errors++; $display("FAIL long_ack_lat: got %0d late acks expected 0", bl); end
        checks++; if (rx_data !== P_LONG) begin errors++; $display("FAIL long_data: got %0h expected %0h", rx_data, P_LONG); end
        checks++; if (ok_cnt !== 16'd2 || last_bad !== 1'b0) begin errors++; $display("FAIL long_ok: got cnt %0d bad %0b expected 2/0", ok_cnt, last_bad); end
    endtask

    task automatic test_bad_nibble;
        int bl;
        logic [71:0] p;
        push(P_SHORT);
        p = P_SHORT;
        p[11:8] = 4'h3;
        send_pkt(p, 10, bl);
        checks++; if (last_bad !== 1'b1) begin errors++; $display("FAIL nib_bad: got %0b expected 1", last_bad); end
        checks++; if (bad_cnt !== 16'd1 || ok_cnt !== 16'd2) begin errors++; $display("FAIL nib_cnts: got bad %0d ok %0d expected 1/2", bad_cnt, ok_cnt); end
        checks++; if (rx_data !== 72'h300) begin errors++; $display("FAIL nib_data: got %0h expected 300", rx_data); end
    endtask

    task automatic test_fifo_ovf;
        int lat, bl;
        logic prev;
        exp_data = P_SHORT;
        exp_vld = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge tb_clk);
            if (i == 6) begin checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_at7: got %0b expected 0", full); end end
            if (i == 7) begin checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_at8: got %0b expected 1", full); end end
        end
        exp_vld = 1'b0;
        checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL ovf_cnt: got %0d expected 1", ovf_cnt); end
        prev = ack;
        link = link ^ EOP;
        repeat (2) @(negedge tb_clk);
        exp_vld = 1'b1;
        @(negedge tb_clk);
        exp_vld = 1'b0;
        checks++; if (full !== 1'b1 || ovf_cnt !== 16'd1) begin errors++; $display("FAIL push_pop_full: got full %0b ovf %0d expected 1/1", full, ovf_cnt); end
        checks++; if (bad_cnt !== 16'd2) begin errors++; $display("FAIL push_pop_bad: got %0d expected 2", bad_cnt); end
        lat = 3;
        while (ack === prev && lat < 50) begin
            @(negedge tb_clk);
            lat++;
        end
        checks++; if (lat != ACK_LAT) begin errors++; $display("FAIL push_pop_ack: got %0d expected %0d", lat, ACK_LAT); end
        bl = 0;
        for (int i = 0; i < 8; i++) begin
            send_sym(EOP, lat);
            if (lat != ACK_LAT) bl++;
        end
        checks++; if (bl != 0 || orphan_cnt !== 16'd0) begin errors++; $display("FAIL drain: got late %0d orphans %0d expected 0/0", bl, orphan_cnt); end
        checks++; if (full !== 1'b0 || bad_cnt !== 16'd10) begin errors++; $display("FAIL drain_state: got full %0b bad %0d expected 0/10", full, bad_cnt); end
    endtask

    task automatic test_orphan;
        int lat;
        send_sym(EOP, lat);
        checks++; if (orphan_cnt !== 16'd1) begin errors++; $display("FAIL orphan_cnt: got %0d expected 1", orphan_cnt); end
        checks++; if (bad_cnt !== 16'd11 || last_bad !== 1'b1) begin errors++; $display("FAIL orphan_bad: got %0d/%0b expected 11/1", bad_cnt, last_bad); end
    endtask

    task automatic test_sym_err;
        int lat, bl;
        push(P_SHORT);
        bl = 0;
        for (int i = 0; i < 4; i++) begin
            send_sym(enc(P_SHORT[i*4 +: 4]), lat);
            if (lat != ACK_LAT) bl++;
        end
        send_sym(7'b1010000, lat);
        checks++; if (lat != ACK_LAT) begin errors++; $display("FAIL symerr_ack: got %0d expected %0d", lat, ACK_LAT); end
        checks++; if (sym_cnt !== 16'd1) begin errors++; $display("FAIL symerr_cnt: got %0d expected 1", sym_cnt); end
        for (int i = 4; i < 10; i++) begin
            send_sym(enc(P_SHORT[i*4 +: 4]), lat);
            if (lat != ACK_LAT) bl++;
        end
        send_sym(EOP, lat);
        if (lat != ACK_LAT) bl++;
        checks++; if (bl != 0) begin errors++; $display("FAIL symerr_lat: got %0d late acks expected 0", bl); end
        checks++; if (last_bad !== 1'b1 || bad_cnt !== 16'd12 || ok_cnt !== 16'd2) begin
            errors++; $display("FAIL symerr_pkt: got bad %0b cnt %0d ok %0d expected 1/12/2", last_bad, bad_cnt, ok_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bl;
        push(P_SHORT);
        for (int i = 0; i < 3; i++) send_sym(enc(P_SHORT[i*4 +: 4]), lat);
        tb_rst = 1'b1;
        #1;
        checks++; if (ack !== 1'b0 || rx_data !== 72'h0 || rx_vld !== 1'b0 || bad !== 1'b0) begin
            errors++; $display("FAIL mid_rst_out: got ack %0b data %0h vld %0b bad %0b expected all 0", ack, rx_data, rx_vld, bad);
        end
        checks++; if ({ok_cnt, bad_cnt, orphan_cnt, ovf_cnt, sym_cnt} !== 80'h0) begin
            errors++; $display("FAIL mid_rst_cnts: got %0h expected 0", {ok_cnt, bad_cnt, orphan_cnt, ovf_cnt, sym_cnt});
        end
        repeat (3) @(negedge tb_clk);
        tb_rst = 1'b0;
        @(negedge tb_clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mid_rst_ack: got %0b expected 1", ack); end
        send_pkt(P_SHORT, 10, bl);
        checks++; if (orphan_cnt !== 16'd1 || bad_cnt !== 16'd1) begin errors++; $display("FAIL mid_rst_fifo: got orphan %0d bad %0d expected 1/1", orphan_cnt, bad_cnt); end
        checks++; if (rx_data !== P_SHORT || bl != 0) begin errors++; $display("FAIL mid_rst_flits: got %0h late %0d expected %0h/0", rx_data, bl, P_SHORT); end
        push(P_SHORT);
        send_pkt(P_SHORT, 10, bl);
        checks++; if (ok_cnt !== 16'd1 || last_bad !== 1'b0) begin errors++; $display("FAIL mid_rst_ok: got %0d/%0b expected 1/0", ok_cnt, last_bad); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vld_seen = 0;
        last_bad = 1'b0;
        tb_rst = 1'b1;
        link = 7'h0;
        exp_vld = 1'b0;
        exp_data = 72'h0;
        test_reset();
        test_short_pkt();
        test_long_pkt();
        test_bad_nibble();
        test_fifo_ovf();
        test_orphan();
        test_sym_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
